// File: rtl/riscv_pkg.sv
// Shared core types: port identifiers for the OBI memory arbiter and its lock FSM states.
package riscv_pkg;
  typedef enum logic {PORT_FETCH = 1'b0, PORT_LSU = 1'b1} obi_port_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT_GNT = 1'b1} obi_lock_e;
  localparam int OBI_MAX_OUT_DEF = 2;
endpackage

// File: rtl/obi_mem_arbiter_id_fifo.sv
// In-order FIFO of request owners; one entry per accepted, not yet answered transaction.
module obi_id_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = OBI_MAX_OUT_DEF,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  obi_port_e        push_id,
  input  logic             pop,
  output obi_port_e        head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] cnt
);
  obi_port_e        id_q [DEPTH];
  obi_port_e        id_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign cnt     = cnt_q;
  assign head    = id_q[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    id_d   = id_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) begin
      id_d[wptr_q] = push_id;
      wptr_d       = ptr_inc(wptr_q);
    end
    if (do_pop) rptr_d = ptr_inc(rptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) id_q[i] <= PORT_FETCH;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      id_q   <= id_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
endmodule

// File: rtl/obi_mem_arbiter.sv
// Round-robin 2:1 arbiter sharing one OBI memory between fetch and LSU; responses routed by ID FIFO.
module obi_mem_arbiter
  import riscv_pkg::*;
#(
  parameter int MAX_OUT = OBI_MAX_OUT_DEF,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              f_proc_req,
  input  logic              f_we,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic [DATA_W-1:0] f_wdata,
  output logic              f_mem_rdy,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_valid,
  input  logic              l_proc_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_mem_rdy,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_valid,
  output logic              mem_proc_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_mem_rdy,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              err
);
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  obi_lock_e        state_q, state_d;
  obi_port_e        sel_q, sel_d, last_grant_q, last_grant_d, sel, head;
  logic             err_q, err_d;
  logic             sel_req, req_int, accept, pop, empty, full, blocked;
  logic [CNT_W-1:0] cnt;

  // Blocking uses only the registered count, so a same-cycle pop cannot reopen the grant.
  assign blocked = (cnt == CNT_W'(MAX_OUT));

  always_comb begin
    sel = sel_q;
    if (state_q == ST_IDLE) begin
      if (f_proc_req && l_proc_req)
        sel = (last_grant_q == PORT_FETCH) ? PORT_LSU : PORT_FETCH;
      else if (l_proc_req) sel = PORT_LSU;
      else                 sel = PORT_FETCH;
    end
  end

  assign sel_req = (sel == PORT_LSU) ? l_proc_req : f_proc_req;
  assign req_int = sel_req && !blocked;
  assign accept  = req_int && mem_mem_rdy;
  assign pop     = mem_valid && !empty;

  // Port outputs are forced low during reset even though the inputs may be active.
  assign mem_proc_req = RSTn && req_int;
  assign f_mem_rdy    = RSTn && accept && (sel == PORT_FETCH);
  assign l_mem_rdy    = RSTn && accept && (sel == PORT_LSU);
  assign mem_we       = RSTn && ((sel == PORT_LSU) ? l_we : f_we);
  assign mem_addr     = RSTn ? ((sel == PORT_LSU) ? l_addr : f_addr) : '0;
  assign mem_wdata    = RSTn ? ((sel == PORT_LSU) ? l_wdata : f_wdata) : '0;
  assign f_rdata      = RSTn ? mem_rdata : '0;
  assign l_rdata      = RSTn ? mem_rdata : '0;
  assign f_valid      = pop && (head == PORT_FETCH);
  assign l_valid      = pop && (head == PORT_LSU);
  assign err          = err_q;

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    last_grant_d = last_grant_q;
    err_d        = err_q || (mem_valid && empty);
    if (accept) last_grant_d = sel;
    case (state_q)
      ST_IDLE:
        if (req_int && !mem_mem_rdy) begin
          state_d = ST_WAIT_GNT;
          sel_d   = sel;
        end
      ST_WAIT_GNT:
        if (accept || !sel_req) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q      <= ST_IDLE;
      sel_q        <= PORT_FETCH;
      last_grant_q <= PORT_FETCH;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  obi_id_fifo #(.DEPTH(MAX_OUT)) u_fifo (
    .clk     (CLK),
    .rst_n   (RSTn),
    .push    (accept),
    .push_id (sel),
    .pop     (pop),
    .head    (head),
    .full    (full),
    .empty   (empty),
    .cnt     (cnt)
  );

  // Arbitration already withholds requests at capacity, so a full FIFO must never see a push.
  always_ff @(posedge CLK) begin
    if (RSTn) assert (!(accept && full));
  end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Directed bench for obi_mem_arbiter: routing, round-robin, lock, capacity, err and reset behaviour.
module tb_obi_mem_arbiter;
  import riscv_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        f_proc_req, f_we, f_mem_rdy, f_valid;
  logic [31:0] f_addr, f_wdata, f_rdata;
  logic        l_proc_req, l_we, l_mem_rdy, l_valid;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic        mem_proc_req, mem_we, mem_mem_rdy, mem_valid, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  int          total = 0;
  int          bad = 0;
  obi_port_e   g, p;

  always #5 CLK = ~CLK;

  obi_mem_arbiter #(.MAX_OUT(2), .ADDR_W(32), .DATA_W(32)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .f_proc_req(f_proc_req), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_mem_rdy(f_mem_rdy), .f_rdata(f_rdata), .f_valid(f_valid),
    .l_proc_req(l_proc_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_mem_rdy(l_mem_rdy), .l_rdata(l_rdata), .l_valid(l_valid),
    .mem_proc_req(mem_proc_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mem_rdy(mem_mem_rdy), .mem_rdata(mem_rdata), .mem_valid(mem_valid), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    f_proc_req = 0; f_we = 0; f_addr = 0; f_wdata = 0;
    l_proc_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    mem_mem_rdy = 0; mem_valid = 0; mem_rdata = 0;
  endtask

  initial begin
    // Reset: outputs low even with an active request on the inputs
    idle();
    f_proc_req = 1; f_addr = 32'h100; mem_mem_rdy = 1; mem_rdata = 32'hDEADBEEF;
    #2;
    chk("rst_req", mem_proc_req, 0);
    chk("rst_frdy", f_mem_rdy, 0);
    chk("rst_rdata", f_rdata, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", 32'(dut.cnt), 0);
    tick(); tick();
    RSTn = 1;
    idle();

    // Fetch-only reads, response one cycle after acceptance
    mem_mem_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      f_proc_req = (i < 3);
      f_addr     = 32'h100 + 32'(i * 4);
      mem_valid  = (i > 0);
      mem_rdata  = 32'h1000 + 32'(i);
      #1;
      chk("f_only_rdy", f_mem_rdy, 32'(i < 3));
      if (i < 3) chk("f_only_addr", mem_addr, 32'h100 + 32'(i * 4));
      chk("f_only_fval", f_valid, 32'(i > 0));
      chk("f_only_lval", l_valid, 0);
      chk("f_only_rdata", f_rdata, 32'h1000 + 32'(i));
      tick();
    end
    idle();
    #1;
    chk("f_only_err", err, 0);
    chk("f_only_cnt", 32'(dut.cnt), 0);

    RSTn = 0;
    tick();
    RSTn = 1;

    // Continuous contention: LSU first, then alternating; responses follow grant order
    f_addr = 32'h100; l_addr = 32'h2000; l_we = 1; l_wdata = 32'h55;
    mem_mem_rdy = 1;
    for (int i = 0; i < 5; i++) begin
      f_proc_req = (i < 4);
      l_proc_req = (i < 4);
      mem_valid  = (i > 0);
      #1;
      if (i < 4) begin
        g = (i % 2 == 0) ? PORT_LSU : PORT_FETCH;
        chk("rr_addr", mem_addr, (g == PORT_LSU) ? 32'h2000 : 32'h100);
        chk("rr_lrdy", l_mem_rdy, 32'(g == PORT_LSU));
        chk("rr_frdy", f_mem_rdy, 32'(g == PORT_FETCH));
        chk("rr_we", mem_we, 32'(g == PORT_LSU));
      end
      if (i > 0) begin
        p = ((i - 1) % 2 == 0) ? PORT_LSU : PORT_FETCH;
        chk("rr_lval", l_valid, 32'(p == PORT_LSU));
        chk("rr_fval", f_valid, 32'(p == PORT_FETCH));
      end
      tick();
    end
    idle();
    f_addr = 32'h100; l_addr = 32'h2000;

    // Lock: LSU stalled 3 cycles while fetch joins; address held until acceptance
    l_proc_req = 1;
    #1;
    chk("lk0_req", mem_proc_req, 1);
    chk("lk0_addr", mem_addr, 32'h2000);
    chk("lk0_lrdy", l_mem_rdy, 0);
    tick();
    f_proc_req = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("lk_addr", mem_addr, 32'h2000);
      chk("lk_frdy", f_mem_rdy, 0);
      tick();
    end
    mem_mem_rdy = 1;
    #1;
    chk("lk3_lrdy", l_mem_rdy, 1);
    chk("lk3_frdy", f_mem_rdy, 0);
    chk("lk3_addr", mem_addr, 32'h2000);
    tick();
    #1;
    chk("lk4_frdy", f_mem_rdy, 1);
    chk("lk4_lrdy", l_mem_rdy, 0);
    chk("lk4_addr", mem_addr, 32'h100);
    tick();

    // Capacity: two outstanding block the grant; a pop frees it only the next cycle
    #1;
    chk("cap_req", mem_proc_req, 0);
    chk("cap_frdy", f_mem_rdy, 0);
    chk("cap_lrdy", l_mem_rdy, 0);
    chk("cap_cnt", 32'(dut.cnt), 2);
    tick();
    mem_valid = 1;
    #1;
    chk("cap_pop_lval", l_valid, 1);
    chk("cap_pop_fval", f_valid, 0);
    chk("cap_pop_req", mem_proc_req, 0);
    tick();
    #1;
    chk("cap_res_fval", f_valid, 1);
    chk("cap_res_lrdy", l_mem_rdy, 1);
    chk("cap_res_addr", mem_addr, 32'h2000);
    tick();
    f_proc_req = 0; l_proc_req = 0;
    #1;
    chk("cap_end_lval", l_valid, 1);
    tick();
    mem_valid = 0;
    #1;
    chk("cap_end_cnt", 32'(dut.cnt), 0);
    chk("cap_end_err", err, 0);

    // Spurious response: no valid routed, err sticky
    mem_valid = 1;
    #1;
    chk("sp_fval", f_valid, 0);
    chk("sp_lval", l_valid, 0);
    chk("sp_err_pre", err, 0);
    tick();
    mem_valid = 0;
    #1;
    chk("sp_err", err, 1);
    tick(); tick();
    chk("sp_err_hold", err, 1);

    // Reset with two outstanding; stale response afterwards flags err
    f_proc_req = 1; f_addr = 32'h300; mem_mem_rdy = 1; mem_rdata = 32'hCAFE;
    tick(); tick();
    chk("mr_cnt_pre", 32'(dut.cnt), 2);
    RSTn = 0;
    #1;
    chk("mr_cnt", 32'(dut.cnt), 0);
    chk("mr_err", err, 0);
    chk("mr_req", mem_proc_req, 0);
    chk("mr_frdy", f_mem_rdy, 0);
    chk("mr_rdata", f_rdata, 0);
    tick();
    RSTn = 1;
    f_proc_req = 0;
    mem_valid = 1;
    #1;
    chk("mr_stale_fval", f_valid, 0);
    tick();
    mem_valid = 0;
    #1;
    chk("mr_stale_err", err, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/obi_mem_arbiter.md
# obi_mem_arbiter

Two-to-one arbiter that lets the core's fetch port and LSU port share a single OBI-style memory (one `mem_wrap_fake` instance or a unified SRAM). It grants the memory request channel to one requester per cycle with round-robin fairness. It holds a grant until the memory accepts it, and records each accepted transaction's owner in an in-order ID FIFO. Each response `valid` is routed back to the port that issued the request. The block sits between `riscv_core` and the memory wrapper.

## Interface
- `MAX_OUT`, 2, maximum accepted-but-unanswered transactions (1..8).
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.

Ports:
- `CLK`  in  1  clock, rising edge.
- `RSTn`  in  1  reset, asynchronous, active-low.
- `f_proc_req` / `l_proc_req`  in  1  fetch / LSU request.
- `f_we` / `l_we`  in  1  write enable.
- `f_addr` / `l_addr`  in  ADDR_W  address.
- `f_wdata` / `l_wdata`  in  DATA_W  write data.
- `f_mem_rdy` / `l_mem_rdy`  out  1  request accepted (grant).
- `f_rdata` / `l_rdata`  out  DATA_W  response data (both driven from `mem_rdata`).
- `f_valid` / `l_valid`  out  1  response valid for that port.
- `mem_proc_req`, `mem_we`, `mem_addr`, `mem_wdata`  out  request channel to the memory.
- `mem_mem_rdy`  in  1  memory accepts request.
- `mem_rdata`  in  DATA_W  memory response data.
- `mem_valid`  in  1  memory response valid.
- `err`  out  1  sticky; set when `mem_valid` arrives with the ID FIFO empty.

## Operation
- A transfer is accepted on a cycle where `mem_proc_req && mem_mem_rdy`.
- The selected port's `*_mem_rdy` equals `mem_mem_rdy`. The other port's `*_mem_rdy` is 0.
- Selection:
  - If `locked`, keep `sel`.
  - Otherwise, if only one port requests, select it.
  - If both request, select the port opposite `last_grant`.
- Selection rules apply only when `cnt < MAX_OUT`.
- When `cnt == MAX_OUT`:
  - `mem_proc_req` is 0 and both `*_mem_rdy` are 0.
  - A pop in the same cycle does not unblock the grant. There is no combinational path from `mem_valid` to requests.
- Lock FSM, states IDLE and WAIT_GNT:
  - IDLE -> WAIT_GNT when `mem_proc_req && !mem_mem_rdy`. `sel` is frozen, which keeps the memory-side address stable.
  - WAIT_GNT -> IDLE on acceptance.
  - WAIT_GNT -> IDLE if the selected port drops `proc_req` (protocol violation, lock released).
- On acceptance:
  - Push `sel` into the ID FIFO.
  - `last_grant <= sel`.
- On `mem_valid`:
  - Pop the FIFO head.
  - Assert `f_valid` if head = FETCH, or `l_valid` if head = LSU, for that cycle only.
  - If the FIFO is empty, assert no valid and set `err`.
- Push and pop in the same cycle: `cnt` is unchanged and both pointers advance.
- Pointers wrap modulo `MAX_OUT`. `cnt` is `$clog2(MAX_OUT+1)` bits wide.

## Timing
- Zero added latency on both channels. Request and response paths are combinational through `sel` and the FIFO head.
- State updates (`cnt`, pointers, `last_grant`, FSM, `err`) occur at the rising edge of `CLK`.
- Reset values:
  - FSM = IDLE, `cnt` = 0, pointers = 0, `last_grant` = FETCH, `err` = 0.
  - All outputs are 0 while `RSTn` = 0.
- The first contention after reset goes to LSU.
- Reset mid-transaction discards all outstanding IDs. A late `mem_valid` after reset sets `err`.

## Structure
- `riscv_pkg` gains `typedef enum logic {PORT_FETCH = 1'b0, PORT_LSU = 1'b1} obi_port_e` and `OBI_MAX_OUT_DEF = 2`.
- Sub-module `obi_id_fifo`: synchronous FIFO of `obi_port_e`, depth `MAX_OUT`, with push/pop/full/empty/`cnt` outputs and asynchronous active-low reset.
- The top level contains the selection mux, the round-robin register and the lock FSM.

## Test plan
- Fetch-only reads, memory ready every cycle, `mem_valid` one cycle after acceptance: responses return only on `f_valid`, `l_valid` stays 0, `err` stays 0.
- Both ports request continuously at addresses 0x100 (fetch) and 0x2000 (LSU): grants alternate LSU, FETCH, LSU, ..., and the `f_valid`/`l_valid` order matches the grant order.
- LSU requests while `mem_mem_rdy` = 0 for 3 cycles, and fetch starts requesting in cycle 2: `mem_addr` stays 0x2000 until acceptance, then the fetch is granted.
- `MAX_OUT` = 2, two accepted requests with no response: a third request sees `*_mem_rdy` = 0. After one `mem_valid`, the grant resumes in the following cycle.
- `mem_valid` with nothing outstanding: `err` rises and stays 1 until `RSTn` is asserted.
- `RSTn` asserted low with 2 transactions outstanding: `cnt` = 0 and outputs are 0 immediately; after release, a stale `mem_valid` sets `err`.
